// File: rtl/us_timer.sv
// us_timer: microsecond timeout timer with one-shot and periodic modes.
module us_timer #(
  parameter int CNT_W = 16,
  parameter int PRD_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             pluse_us,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] len_us,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_us,
  output logic [PRD_W-1:0] prd_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [CNT_W-1:0] len_reg;
  logic             mode_reg;
  logic [CNT_W-1:0] cnt_nx;
  logic             term;
  assign cnt_nx = cnt_us + 1'b1;
  assign term   = (state == RUN) && pluse_us && (cnt_nx == len_reg);
  assign busy   = state;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      cnt_us   <= '0;
      prd_cnt  <= '0;
      len_reg  <= '0;
      mode_reg <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      done  <= 1'b0;
    end else if (start) begin
      // a zero-length start expires immediately without entering RUN
      state    <= (len_us == '0) ? IDLE : RUN;
      done     <= (len_us == '0);
      len_reg  <= len_us;
      mode_reg <= mode;
      cnt_us   <= '0;
      prd_cnt  <= (len_us == '0) ? PRD_W'(1) : '0;
    end else if (term) begin
      state   <= mode_reg ? RUN : IDLE;
      done    <= 1'b1;
      cnt_us  <= mode_reg ? '0 : len_reg;
      prd_cnt <= prd_cnt + 1'b1;
    end else begin
      done   <= 1'b0;
      cnt_us <= (state == RUN && pluse_us) ? cnt_nx : cnt_us;
    end
  end
endmodule

// File: tb/tb_us_timer.sv
// tb_us_timer: vector table with expected-result queue, plus multi-cycle corner sequences.
module tb_us_timer;
  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        pluse_us = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [15:0] len_us = '0;
  logic        busy, done;
  logic [15:0] cnt_us;
  logic [7:0]  prd_cnt;
  int checks = 0, errors = 0;

  us_timer dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .start(start),
    .stop(stop), .mode(mode), .len_us(len_us), .busy(busy), .done(done),
    .cnt_us(cnt_us), .prd_cnt(prd_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic pl, st, sp, md;
    logic [15:0] len;
    logic b, d;
    logic [15:0] c;
    logic [7:0] p;
  } vec_t;
  typedef struct {
    int idx;
    logic b, d;
    logic [15:0] c;
    logic [7:0] p;
  } exp_t;

  vec_t tv[31];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic pl, input logic st, input logic sp, input logic md, input logic [15:0] len);
    pluse_us = pl; start = st; stop = sp; mode = md; len_us = len;
    @(posedge clk_sys);
    #1;
    pluse_us = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int first_done, n_done, n_low;
    exp_t e;
    //          pl st sp md len   busy done cnt prd
    tv[0]  = '{0, 0, 0, 0, 16'd0, 0, 0, 16'd0, 8'd0};
    tv[1]  = '{1, 0, 1, 0, 16'd0, 0, 0, 16'd0, 8'd0};
    tv[2]  = '{0, 1, 0, 0, 16'd0, 0, 1, 16'd0, 8'd1};
    tv[3]  = '{0, 0, 0, 0, 16'd0, 0, 0, 16'd0, 8'd1};
    tv[4]  = '{1, 1, 0, 0, 16'd3, 1, 0, 16'd0, 8'd0};
    tv[5]  = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[6]  = '{0, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[7]  = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd2, 8'd0};
    tv[8]  = '{1, 0, 0, 0, 16'd0, 0, 1, 16'd3, 8'd1};
    tv[9]  = '{1, 0, 0, 0, 16'd0, 0, 0, 16'd3, 8'd1};
    tv[10] = '{0, 1, 0, 1, 16'd2, 1, 0, 16'd0, 8'd0};
    tv[11] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[12] = '{1, 0, 0, 0, 16'd0, 1, 1, 16'd0, 8'd1};
    tv[13] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd1};
    tv[14] = '{1, 0, 0, 0, 16'd0, 1, 1, 16'd0, 8'd2};
    tv[15] = '{1, 1, 1, 0, 16'd7, 0, 0, 16'd0, 8'd2};
    tv[16] = '{0, 1, 0, 0, 16'd4, 1, 0, 16'd0, 8'd0};
    tv[17] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[18] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd2, 8'd0};
    tv[19] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd3, 8'd0};
    tv[20] = '{1, 0, 1, 0, 16'd0, 0, 0, 16'd3, 8'd0};
    tv[21] = '{0, 1, 0, 1, 16'd2, 1, 0, 16'd0, 8'd0};
    tv[22] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[23] = '{1, 1, 0, 0, 16'd5, 1, 0, 16'd0, 8'd0};
    tv[24] = '{1, 0, 0, 0, 16'd0, 1, 0, 16'd1, 8'd0};
    tv[25] = '{0, 1, 1, 0, 16'd2, 0, 0, 16'd1, 8'd0};
    tv[26] = '{0, 1, 0, 1, 16'd1, 1, 0, 16'd0, 8'd0};
    tv[27] = '{1, 0, 0, 0, 16'd0, 1, 1, 16'd0, 8'd1};
    tv[28] = '{1, 0, 0, 0, 16'd0, 1, 1, 16'd0, 8'd2};
    tv[29] = '{0, 0, 0, 0, 16'd0, 1, 0, 16'd0, 8'd2};
    tv[30] = '{0, 0, 1, 0, 16'd0, 0, 0, 16'd0, 8'd2};

    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(cnt_us), 0);
    chk("rst_prd", 32'(prd_cnt), 0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      sbq.push_back('{i, tv[i].b, tv[i].d, tv[i].c, tv[i].p});
      drive(tv[i].pl, tv[i].st, tv[i].sp, tv[i].md, tv[i].len);
      e = sbq.pop_front();
      chk($sformatf("v%0d_busy", e.idx), 32'(busy), 32'(e.b));
      chk($sformatf("v%0d_done", e.idx), 32'(done), 32'(e.d));
      chk($sformatf("v%0d_cnt", e.idx), 32'(cnt_us), 32'(e.c));
      chk($sformatf("v%0d_prd", e.idx), 32'(prd_cnt), 32'(e.p));
    end

    // one-shot with a tick every 100 cycles
    drive(0, 1, 0, 0, 16'd3);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 400; k++) begin
      drive((k % 100) == 0, 0, 0, 0, 16'd0);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    chk("slow_done_window", 32'(first_done >= 201 && first_done <= 301), 1);
    chk("slow_done_count", 32'(n_done), 1);
    chk("slow_busy", 32'(busy), 0);
    chk("slow_cnt", 32'(cnt_us), 3);

    // periodic len 1 with a tick every cycle: done continuous, prd_cnt wraps
    drive(0, 1, 0, 1, 16'd1);
    chk("wrap_start_busy", 32'(busy), 1);
    n_low = 0;
    for (int k = 1; k <= 300; k++) begin
      drive(1, 0, 0, 0, 16'd0);
      if (!done) n_low++;
      if (k == 255) chk("wrap_255", 32'(prd_cnt), 255);
      if (k == 256) chk("wrap_0", 32'(prd_cnt), 0);
    end
    chk("wrap_done_cont", 32'(n_low), 0);
    chk("wrap_300", 32'(prd_cnt), 44);
    drive(1, 1, 1, 0, 16'd9);
    chk("wrap_ststop_busy", 32'(busy), 0);
    chk("wrap_ststop_done", 32'(done), 0);
    chk("wrap_ststop_prd", 32'(prd_cnt), 44);

    // asynchronous reset mid-run
    drive(0, 1, 0, 0, 16'd10);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 16'd0);
    chk("ar_pre_cnt", 32'(cnt_us), 5);
    chk("ar_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_cnt", 32'(cnt_us), 0);
    chk("ar_prd", 32'(prd_cnt), 0);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    drive(1, 0, 1, 0, 16'd0);
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_done", 32'(done), 0);
    drive(0, 1, 0, 0, 16'd2);
    chk("ar_restart_busy", 32'(busy), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
